// File: rtl/banked_mem.sv
// banked_mem: NUM_BANKS interleaved single-port banks, fixed access latency,
// valid/ready request port, round-robin arbitrated response port.
// Ports: clk, reset (sync, active low); req_* request channel; resp_*
// response channel; bank_busy shows every bank that is not idle.
module banked_mem #(
  parameter int DATA_W    = 32,
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 6,
  parameter int LATENCY   = 3,
  parameter int TAG_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [BANK_BITS+ROW_BITS-1:0] req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [TAG_W-1:0]              req_tag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_rw,
  output logic [TAG_W-1:0]              resp_tag,
  output logic [BANK_BITS-1:0]          resp_bank,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic [2**BANK_BITS-1:0]       bank_busy
);

  localparam int NB = 2**BANK_BITS;
  localparam int ROWS = 2**ROW_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t              st_q    [NB];
  state_t              st_d    [NB];
  logic [3:0]          cnt_q   [NB];
  logic [3:0]          cnt_d   [NB];
  logic                rw_q    [NB];
  logic                rw_d    [NB];
  logic [ROW_BITS-1:0] row_q   [NB];
  logic [ROW_BITS-1:0] row_d   [NB];
  logic [DATA_W-1:0]   wdata_q [NB];
  logic [DATA_W-1:0]   wdata_d [NB];
  logic [DATA_W-1:0]   rdata_q [NB];
  logic [DATA_W-1:0]   rdata_d [NB];
  logic [TAG_W-1:0]    tag_q   [NB];
  logic [TAG_W-1:0]    tag_d   [NB];
  logic [NB-1:0]       we;

  logic [DATA_W-1:0]   mem [NB][ROWS];

  logic [BANK_BITS-1:0] rr_q;
  logic [BANK_BITS-1:0] rr_d;
  logic [BANK_BITS-1:0] sel;
  logic [BANK_BITS-1:0] idx;
  logic                 found;
  logic                 accept;
  logic                 grant;

  logic [BANK_BITS-1:0] req_bank;
  logic [ROW_BITS-1:0]  req_row;

  assign req_bank = req_addr[BANK_BITS-1:0];
  assign req_row  = req_addr[BANK_BITS+ROW_BITS-1:BANK_BITS];

  assign req_ready = reset && (st_q[req_bank] == IDLE);
  assign accept    = req_valid && req_ready;

  // First DONE bank at or after rr_q; the index wraps by width.
  always_comb begin
    sel   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int i = 0; i < NB; i++) begin
      idx = rr_q + BANK_BITS'(i);
      if (!found && st_q[idx] == DONE) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign resp_valid = reset && found;
  assign grant      = resp_valid && resp_ready;
  assign resp_rw    = resp_valid && rw_q[sel];
  assign resp_tag   = resp_valid ? tag_q[sel] : '0;
  assign resp_bank  = resp_valid ? sel : '0;
  assign resp_rdata = (resp_valid && !rw_q[sel]) ? rdata_q[sel] : '0;

  always_comb begin
    bank_busy = '0;
    for (int b = 0; b < NB; b++)
      bank_busy[b] = reset && (st_q[b] != IDLE);
  end

  always_comb begin
    rr_d = rr_q;
    we   = '0;
    for (int b = 0; b < NB; b++) begin
      st_d[b]    = st_q[b];
      cnt_d[b]   = cnt_q[b];
      rw_d[b]    = rw_q[b];
      row_d[b]   = row_q[b];
      wdata_d[b] = wdata_q[b];
      rdata_d[b] = rdata_q[b];
      tag_d[b]   = tag_q[b];
    end
    for (int b = 0; b < NB; b++) begin
      unique case (st_q[b])
        IDLE: begin
          if (accept && req_bank == BANK_BITS'(b)) begin
            rw_d[b]    = req_rw;
            row_d[b]   = req_row;
            wdata_d[b] = req_wdata;
            tag_d[b]   = req_tag;
            cnt_d[b]   = LAT_M1;
            st_d[b]    = BUSY;
          end
        end
        BUSY: begin
          if (cnt_q[b] == 4'd0) begin
            st_d[b] = DONE;
            if (rw_q[b]) begin
              we[b]      = 1'b1;
              rdata_d[b] = '0;
            end else begin
              rdata_d[b] = mem[b][row_q[b]];
            end
          end else begin
            cnt_d[b] = cnt_q[b] - 4'd1;
          end
        end
        DONE: begin
          if (grant && sel == BANK_BITS'(b))
            st_d[b] = IDLE;
        end
        default: st_d[b] = IDLE;
      endcase
    end
    if (grant)
      rr_d = sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= '0;
      for (int b = 0; b < NB; b++) begin
        st_q[b]    <= IDLE;
        cnt_q[b]   <= '0;
        rw_q[b]    <= 1'b0;
        row_q[b]   <= '0;
        wdata_q[b] <= '0;
        rdata_q[b] <= '0;
        tag_q[b]   <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int b = 0; b < NB; b++) begin
        st_q[b]    <= st_d[b];
        cnt_q[b]   <= cnt_d[b];
        rw_q[b]    <= rw_d[b];
        row_q[b]   <= row_d[b];
        wdata_q[b] <= wdata_d[b];
        rdata_q[b] <= rdata_d[b];
        tag_q[b]   <= tag_d[b];
      end
    end
  end

  // Array keeps its contents through reset; a pending write dies with it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (reset && we[b])
        mem[b][row_q[b]] <= wdata_q[b];
  end

endmodule

// File: tb/tb_banked_mem.sv
// tb_banked_mem: directed and random stimulus for banked_mem, checked
// against a flat memory array and a round-robin pick model.
module tb_banked_mem;

  localparam int DW  = 32;
  localparam int BB  = 3;
  localparam int RB  = 6;
  localparam int LAT = 3;
  localparam int TW  = 4;
  localparam int NB  = 8;
  localparam int AW  = BB + RB;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_rw;
  logic [TW-1:0] resp_tag;
  logic [BB-1:0] resp_bank;
  logic [DW-1:0] resp_rdata;
  logic [NB-1:0] bank_busy;

  banked_mem #(
    .DATA_W(DW), .BANK_BITS(BB), .ROW_BITS(RB),
    .LATENCY(LAT), .TAG_W(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rw(resp_rw), .resp_tag(resp_tag),
    .resp_bank(resp_bank), .resp_rdata(resp_rdata),
    .bank_busy(bank_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model_mem [1<<AW];
  int model_rr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input bit [NB-1:0] pend, input int ptr);
    for (int i = 0; i < NB; i++)
      if (pend[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  // One isolated access: accept, latency window, response, drain.
  task automatic access(input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [TW-1:0] t);
    int b;
    int waited;
    logic [DW-1:0] exp;
    b = int'(a) % NB;
    exp = rw ? '0 : model_mem[a];
    if (rw) model_mem[a] = d;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a;
    req_wdata = d; req_tag = t; resp_ready = 1'b0;
    #1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk("acc_req_ready", req_ready, 1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("acc_lat_valid", resp_valid, 0);
      chk("acc_lat_ready", req_ready, 0);
      chk("acc_lat_busy", bank_busy, 64'(1) << b);
    end
    @(negedge clk);
    chk("acc_valid", resp_valid, 1);
    chk("acc_rw", resp_rw, rw);
    chk("acc_tag", resp_tag, t);
    chk("acc_bank", resp_bank, b);
    chk("acc_rdata", resp_rdata, exp);
    chk("acc_done_ready", req_ready, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("acc_drained", resp_valid, 0);
    chk("acc_idle_busy", bank_busy, 0);
    chk("acc_ready_again", req_ready, 1);
    resp_ready = 1'b0;
    model_rr = (b + 1) % NB;
  endtask

  // One request per masked bank, all parked in DONE, then released.
  task automatic burst(input bit [NB-1:0] mask);
    logic [DW-1:0] exp_d [NB];
    logic [TW-1:0] exp_t [NB];
    logic          exp_w [NB];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          w;
    bit [NB-1:0]   pend;
    int            first;
    int            b;
    resp_ready = 1'b0;
    pend = mask;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) begin
        a = {RB'($urandom), BB'(i)};
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        t = TW'($urandom);
        exp_w[i] = w;
        exp_t[i] = t;
        exp_d[i] = w ? '0 : model_mem[a];
        if (w) model_mem[a] = d;
        @(negedge clk);
        req_valid = 1'b1; req_rw = w; req_addr = a;
        req_wdata = d; req_tag = t;
        #1 chk("burst_req_ready", req_ready, 1);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    first = rr_pick(pend, model_rr);
    for (int h = 0; h < 4; h++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_bank", resp_bank, first);
      chk("hold_tag", resp_tag, exp_t[first]);
      chk("hold_rdata", resp_rdata, exp_d[first]);
      chk("hold_busy", bank_busy, mask);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    while (pend != 0) begin
      b = rr_pick(pend, model_rr);
      chk("rr_valid", resp_valid, 1);
      chk("rr_bank", resp_bank, b);
      chk("rr_rw", resp_rw, exp_w[b]);
      chk("rr_tag", resp_tag, exp_t[b]);
      chk("rr_rdata", resp_rdata, exp_d[b]);
      pend[b] = 1'b0;
      model_rr = (b + 1) % NB;
      @(negedge clk);
    end
    chk("burst_drained", resp_valid, 0);
    chk("burst_idle", bank_busy, 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_bank [$];
    int q_tag  [$];
    int q_cyc  [$];
    logic [DW-1:0] q_data [$];
    logic [DW-1:0] pexp [NB];
    logic [TW-1:0] ptag [NB];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int cnt;
    bit seen;

    reset = 1'b0; req_valid = 1'b1; req_rw = 1'b0;
    req_addr = AW'($urandom); req_wdata = '0; req_tag = '0;
    resp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rw", resp_rw, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_bank", resp_bank, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bank_busy", bank_busy, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", bank_busy, 0);

    // Single write then read-back at address 0x0A
    access(1'b1, AW'(9'h00A), 32'hDEADBEEF, 4'd5);
    access(1'b0, AW'(9'h00A), 32'h0, 4'd6);

    // Fill every location with known random data
    for (int i = 0; i < (1 << AW); i++)
      access(1'b1, AW'(i), $urandom, TW'($urandom));

    // All eight banks in flight, one response per cycle
    resp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        q_bank.push_back(int'(resp_bank));
        q_tag.push_back(int'(resp_tag));
        q_data.push_back(resp_rdata);
        q_cyc.push_back(c);
      end
      if (c < NB) begin
        a = {RB'($urandom), BB'(c)};
        ptag[c] = TW'($urandom);
        pexp[c] = model_mem[a];
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
        req_tag = ptag[c];
        #1 chk("par_req_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
    end
    resp_ready = 1'b0;
    chk("par_count", q_bank.size(), NB);
    if (q_cyc.size() > 0)
      chk("par_first_cycle", q_cyc[0], LAT + 1);
    for (int k = 0; k < q_bank.size() && k < NB; k++) begin
      chk("par_bank", q_bank[k], k);
      chk("par_tag", q_tag[k], ptag[k]);
      chk("par_rdata", q_data[k], pexp[k]);
      chk("par_cycle", q_cyc[k], q_cyc[0] + k);
    end
    model_rr = 0;

    // Arbitration: banks 1, 3, 6 parked together, then 2 and 7
    burst(8'b0100_1010);
    burst(8'b1000_0100);

    // Back-to-back requests to bank 4, read-after-write same row
    a = {RB'($urandom), BB'(4)};
    d = $urandom;
    model_mem[a] = d;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a;
    req_wdata = d; req_tag = 4'd1;
    #1 chk("conf_first_ready", req_ready, 1);
    @(negedge clk);
    req_rw = 1'b0; req_tag = 4'd2; req_wdata = '0;
    resp_ready = 1'b1;
    cnt = 1; seen = 1'b0;
    #1;
    while (!req_ready && cnt < 20) begin
      if (resp_valid) begin
        chk("conf_first_tag", resp_tag, 1);
        chk("conf_first_rw", resp_rw, 1);
        seen = 1'b1;
      end
      @(negedge clk); #1;
      cnt++;
    end
    chk("conf_ready_delay", cnt, LAT + 2);
    chk("conf_first_seen", seen, 1);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    #1;
    while (!resp_valid && cnt < 20) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk("conf_second_lat", cnt, LAT + 1);
    chk("conf_second_tag", resp_tag, 2);
    chk("conf_second_rw", resp_rw, 0);
    chk("conf_second_rdata", resp_rdata, d);
    @(negedge clk);
    chk("conf_drained", resp_valid, 0);
    resp_ready = 1'b0;
    model_rr = 5;

    // Reset one cycle after accepting a write to 0x03
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = AW'(9'h003);
    req_wdata = 32'h55; req_tag = 4'd3;
    #1 chk("mid_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_busy", bank_busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_bank", resp_bank, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_after_busy", bank_busy, 0);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("mid_no_resp", resp_valid, 0);
    end
    model_rr = 0;
    access(1'b0, AW'(9'h003), 32'h0, 4'd7);

    // Random isolated accesses and random parked bursts
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)), AW'($urandom),
             $urandom, TW'($urandom));
    for (int i = 0; i < 20; i++)
      burst(NB'($urandom_range(1, (1 << NB) - 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
